ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 4, maximum consecutive DMA transfers before the CPU is given the port (range 1..15).
REQ-002 Parameter: GUARD_CYCLES, 1, cycles of guaranteed CPU ownership after a MAX_BURST-terminated burst (range 1..7).
REQ-003 Port: clk  in  1  system clock; one clock, all state on its rising edge.
REQ-004 Port: resb  in  1  reset, asynchronous, active-low.
REQ-005 Port: cpu_ab  in  16  CPU address bus.
REQ-006 Port: cpu_we  in  1  CPU write enable.
REQ-007 Port: cpu_do  in  8  CPU write data.
REQ-008 Port: cpu_rdy  out  1  CPU ready; low stalls the CPU, which holds cpu_ab/cpu_we/cpu_do.
REQ-009 Port: cpu_di  out  8  RAM read data returned to the CPU read mux.
REQ-010 Port: dma_req  in  1  DMA requester wants one transfer this cycle.
REQ-011 Port: dma_addr  in  15  DMA RAM address.
REQ-012 Port: dma_we  in  1  DMA write enable.
REQ-013 Port: dma_wdata  in  8  DMA write data.
REQ-014 Port: dma_gnt  out  1  high when DMA owns the port; dma_req&dma_gnt = one accepted transfer.
REQ-015 Port: dma_rvalid  out  1  DMA read data valid.
REQ-016 Port: dma_rdata  out  8  DMA read data.
REQ-017 Port: ram_addr/ram_en/ram_we/ram_wdata  out  15/1/1/8  single-port RAM controls.
REQ-018 Port: ram_rdata  in  8  RAM read data, one-cycle synchronous latency.

Function
REQ-019 States SHALL be CPU, DMA, GUARD; outputs are decoded from the registered state.
REQ-020 CPU: cpu_rdy=1, dma_gnt=0; RAM driven by the CPU; ram_en=(cpu_ab<16'h8000), ram_we=cpu_we&ram_en; dma_req=1 -> DMA next cycle.
REQ-021 DMA: cpu_rdy=0, dma_gnt=1; RAM driven by the DMA; ram_en=dma_req, ram_we=dma_req&dma_we; each accepted transfer increments burst count.
REQ-022 DMA exit: dma_req=0 -> CPU next cycle (no RAM access that cycle); accepted transfer with count reaching MAX_BURST -> GUARD next cycle; count cleared on exit.
REQ-023 GUARD: behaves as CPU; dma_req ignored; after GUARD_CYCLES cycles -> CPU.
REQ-024 dma_rvalid SHALL be high one cycle after an accepted DMA read, with dma_rdata=ram_rdata.
REQ-025 cpu_di SHALL equal ram_rdata in the cycle after a CPU-owned RAM read, and that value SHALL be captured in a hold register; otherwise cpu_di SHALL be the hold register.
REQ-026 The hold register SHALL NOT change during DMA or GUARD cycles without a CPU RAM read, so data for the last pre-stall access survives the stall.
REQ-027 CPU accesses with cpu_ab>=16'h8000 SHALL produce ram_en=0 and SHALL NOT update the hold register.
REQ-028 No CPU write SHALL reach RAM while cpu_rdy=0.

Reset
REQ-029 resb low SHALL asynchronously force: state CPU, burst/guard counters 0, cpu_rdy=1, dma_gnt=0, dma_rvalid=0, ram_we=0, hold register 8'hEA (NOP).
REQ-030 Reset mid-burst SHALL drop dma_gnt and ram_we immediately; the interrupted transfer is not completed.

Structure
REQ-031 State enum, RAM_TOP=16'h8000 and NOP_OPCODE=8'hEA SHALL live in shared package sfot_bus_pkg.
REQ-032 Flat implementation; no sub-module.

Verification
REQ-033 CPU reads 16'h0010 (RAM=8'h5A), no DMA -> cpu_di=8'h5A next cycle, cpu_rdy constantly 1.
REQ-034 dma_req held high for 10 cycles, MAX_BURST=4, GUARD_CYCLES=1 -> gnt pattern 4 on, 1 off, 4 on, 1 off; cpu_rdy is the inverse of gnt.
REQ-035 CPU reads 16'h0020 (8'h33), then DMA writes 8'hFF to 15'h0020 -> after the stall, cpu_di=8'h33 until the next CPU read.
REQ-036 DMA read of 15'h7FFF -> dma_rvalid one cycle later with stored value; CPU read of 16'h8003 -> ram_en=0.
REQ-037 resb low during the second burst cycle -> dma_gnt=0, cpu_rdy=1 and cpu_di=8'hEA before the next edge.

Source files
------------

// File: rtl/sfot_bus_pkg.sv
// Shared bus definitions for the RAM arbiter: owner states and the fixed
// values of the CPU memory map.
package sfot_bus_pkg;

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_DMA   = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  localparam logic [15:0] RAM_TOP    = 16'h8000;
  localparam logic [7:0]  NOP_OPCODE = 8'hEA;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between a stallable CPU and a DMA requester, with
// bounded DMA bursts followed by a guaranteed CPU window.
module ram_arbiter
  import sfot_bus_pkg::*;
#(
  parameter int MAX_BURST    = 4,
  parameter int GUARD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resb,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_do,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_di,
  input  logic        dma_req,
  input  logic [14:0] dma_addr,
  input  logic        dma_we,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [14:0] ram_addr,
  output logic        ram_en,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  arb_state_e state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic [2:0] guard_q, guard_d;
  logic       cpu_rd_q, dma_rd_q;
  logic [7:0] hold_q;
  logic       cpu_own, cpu_hit, accept, we_raw;

  assign cpu_own = (state_q != ST_DMA);
  assign cpu_hit = (cpu_ab < RAM_TOP);
  assign accept  = dma_gnt & dma_req;

  assign cpu_rdy   = cpu_own;
  assign dma_gnt   = ~cpu_own;
  assign ram_addr  = cpu_own ? cpu_ab[14:0] : dma_addr;
  assign ram_en    = cpu_own ? cpu_hit : dma_req;
  assign ram_wdata = cpu_own ? cpu_do : dma_wdata;
  assign we_raw    = cpu_own ? (cpu_we & cpu_hit) : (dma_req & dma_we);
  // Reset must kill an in-flight write immediately, not at the next edge.
  assign ram_we    = we_raw & resb;

  assign cpu_di     = cpu_rd_q ? ram_rdata : hold_q;
  assign dma_rvalid = dma_rd_q;
  assign dma_rdata  = ram_rdata;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    guard_d = guard_q;
    case (state_q)
      ST_CPU: if (dma_req) state_d = ST_DMA;
      ST_DMA: begin
        if (!dma_req) begin
          state_d = ST_CPU;
          burst_d = '0;
        end else if (burst_q == 4'(MAX_BURST - 1)) begin
          state_d = ST_GUARD;
          burst_d = '0;
          guard_d = '0;
        end else begin
          burst_d = burst_q + 4'd1;
        end
      end
      ST_GUARD: begin
        // The last guard cycle already acts as a CPU cycle, so a pending
        // request is honoured without an extra idle CPU cycle.
        if (guard_q == 3'(GUARD_CYCLES - 1)) begin
          state_d = dma_req ? ST_DMA : ST_CPU;
          guard_d = '0;
        end else begin
          guard_d = guard_q + 3'd1;
        end
      end
      default: state_d = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      state_q  <= ST_CPU;
      burst_q  <= '0;
      guard_q  <= '0;
      cpu_rd_q <= 1'b0;
      dma_rd_q <= 1'b0;
      hold_q   <= NOP_OPCODE;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      guard_q  <= guard_d;
      cpu_rd_q <= cpu_own & cpu_hit & ~cpu_we;
      dma_rd_q <= accept & ~dma_we;
      if (cpu_rd_q) hold_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        resb;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic        cpu_rdy;
  logic [7:0]  cpu_di;
  logic        dma_req;
  logic [14:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic [14:0] ram_addr;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:32767];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  ram_arbiter #(.MAX_BURST(4), .GUARD_CYCLES(1)) dut (
    .clk(clk), .resb(resb),
    .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
    .cpu_rdy(cpu_rdy), .cpu_di(cpu_di),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_ab = a; cpu_we = 1'b1; cpu_do = d;
    step();
    cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    resb = 1'b0; cpu_ab = 16'h0000; cpu_we = 1'b1; cpu_do = 8'h00;
    dma_req = 1'b0; dma_addr = '0; dma_we = 1'b0; dma_wdata = '0;
    step(); step();
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", cpu_rdy); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", dma_gnt); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", dma_rvalid); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    checks++; if (cpu_di !== 8'hEA) begin errors++; $display("FAIL reset_cpu_di got %h exp ea", cpu_di); end
    cpu_we = 1'b0;
    resb = 1'b1;
    step();
  endtask

  task automatic test_cpu_write();
    cpu_ab = 16'h0010; cpu_we = 1'b1; cpu_do = 8'h5A;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_wdata !== 8'h5A || ram_addr !== 15'h0010)
      begin errors++; $display("FAIL cpu_write got we=%b d=%h a=%h exp 1 5a 0010", ram_we, ram_wdata, ram_addr); end
    step();
    cpu_we = 1'b0;
    cpu_write(16'h0020, 8'h33);
    cpu_write(16'h7FFF, 8'hC3);
    checks++; if (mem[15'h0010] !== 8'h5A) begin errors++; $display("FAIL cpu_write_mem got %h exp 5a", mem[15'h0010]); end
  endtask

  task automatic test_cpu_read();
    cpu_ab = 16'h0010; cpu_we = 1'b0;
    #1;
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL cpu_read_en got en=%b we=%b exp 1 0", ram_en, ram_we); end
    step();
    checks++; if (cpu_di !== 8'h5A) begin errors++; $display("FAIL cpu_read_di got %h exp 5a", cpu_di); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL cpu_read_rdy got %b exp 1", cpu_rdy); end
    cpu_ab = 16'h8003;
    #1;
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL cpu_high_en got %b exp 0", ram_en); end
    step();
    checks++; if (cpu_di !== 8'h5A) begin errors++; $display("FAIL cpu_high_hold got %h exp 5a", cpu_di); end
  endtask

  task automatic test_burst();
    logic [9:0] exp_gnt;
    exp_gnt = 10'b0111101111;
    cpu_ab = 16'h0040; cpu_we = 1'b1; cpu_do = 8'h11;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0000;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (dma_gnt !== exp_gnt[i]) begin errors++; $display("FAIL burst_gnt[%0d] got %b exp %b", i, dma_gnt, exp_gnt[i]); end
      checks++; if (cpu_rdy !== ~exp_gnt[i]) begin errors++; $display("FAIL burst_rdy[%0d] got %b exp %b", i, cpu_rdy, ~exp_gnt[i]); end
      checks++; if (ram_we !== ~exp_gnt[i]) begin errors++; $display("FAIL burst_cpu_we[%0d] got %b exp %b", i, ram_we, ~exp_gnt[i]); end
    end
    dma_req = 1'b0; cpu_we = 1'b0;
    step();
    checks++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1) begin errors++; $display("FAIL burst_end got gnt=%b rdy=%b exp 0 1", dma_gnt, cpu_rdy); end
  endtask

  task automatic test_hold();
    cpu_ab = 16'h0020; cpu_we = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0020; dma_wdata = 8'hFF;
    step();
    checks++; if (dma_gnt !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL hold_dma got gnt=%b we=%b exp 1 1", dma_gnt, ram_we); end
    checks++; if (cpu_di !== 8'h33) begin errors++; $display("FAIL hold_first got %h exp 33", cpu_di); end
    step();
    dma_req = 1'b0;
    checks++; if (cpu_di !== 8'h33) begin errors++; $display("FAIL hold_stall got %h exp 33", cpu_di); end
    checks++; if (mem[15'h0020] !== 8'hFF) begin errors++; $display("FAIL hold_dmawr got %h exp ff", mem[15'h0020]); end
    step();
    checks++; if (cpu_di !== 8'h33 || cpu_rdy !== 1'b1) begin errors++; $display("FAIL hold_after got %h rdy=%b exp 33 1", cpu_di, cpu_rdy); end
    step();
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL hold_reread got %h exp ff", cpu_di); end
  endtask

  task automatic test_dma_read();
    cpu_ab = 16'h8003;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h7FFF;
    #1;
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL dmard_cpu_en got %b exp 0", ram_en); end
    step();
    checks++; if (dma_gnt !== 1'b1 || ram_en !== 1'b1 || dma_rvalid !== 1'b0)
      begin errors++; $display("FAIL dmard_gnt got gnt=%b en=%b rv=%b exp 1 1 0", dma_gnt, ram_en, dma_rvalid); end
    step();
    dma_req = 1'b0;
    checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'hC3) begin errors++; $display("FAIL dmard_data got rv=%b d=%h exp 1 c3", dma_rvalid, dma_rdata); end
    step();
    checks++; if (dma_rvalid !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL dmard_after got rv=%b en=%b exp 0 0", dma_rvalid, ram_en); end
    step();
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL dmard_hold got %h exp ff", cpu_di); end
  endtask

  task automatic test_reset_mid();
    cpu_ab = 16'h0050; cpu_we = 1'b1; cpu_do = 8'h44;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0100; dma_wdata = 8'hAA;
    step(); step();
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", dma_gnt); end
    resb = 1'b0;
    #1;
    checks++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_own got gnt=%b rdy=%b exp 0 1", dma_gnt, cpu_rdy); end
    checks++; if (cpu_di !== 8'hEA) begin errors++; $display("FAIL rstmid_di got %h exp ea", cpu_di); end
    checks++; if (ram_we !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_we got we=%b rv=%b exp 0 0", ram_we, dma_rvalid); end
    dma_req = 1'b0; cpu_we = 1'b0;
    step();
    resb = 1'b1;
    step();
    checks++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_post got gnt=%b rdy=%b exp 0 1", dma_gnt, cpu_rdy); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_burst();
    test_hold();
    test_dma_read();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
